// File: rtl/reflet_float_accumulator_pkg.sv
// rtl/reflet_float_accumulator_pkg.sv - shared binary32 constants and accumulator FSM states
package reflet_float_accumulator_pkg;

  localparam int FLOAT_SIZE = 32;
  localparam int EXP_SIZE   = 8;
  localparam int MANT_SIZE  = 23;
  localparam logic [FLOAT_SIZE-1:0] FLOAT_ZERO = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_ADD   = 2'd2,
    ST_WRITE = 2'd3
  } acc_state_t;

endpackage

// File: rtl/reflet_float_acc_bank.sv
// rtl/reflet_float_acc_bank.sv - per-channel binary32 accumulators with saturating counters
module reflet_float_acc_bank
  import reflet_float_accumulator_pkg::*;
#(
  parameter int channels = 4,
  parameter int cnt_size = 16,
  localparam int CHAN_W  = $clog2(channels)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_en,
  input  logic [CHAN_W-1:0]     clr_chan,
  input  logic                  wr_en,
  input  logic [CHAN_W-1:0]     wr_chan,
  input  logic [FLOAT_SIZE-1:0] wr_data,
  input  logic [CHAN_W-1:0]     acc_chan,
  output logic [FLOAT_SIZE-1:0] acc_float,
  input  logic [CHAN_W-1:0]     rd_chan,
  output logic [FLOAT_SIZE-1:0] rd_float,
  output logic [cnt_size-1:0]   rd_count
);

  logic [FLOAT_SIZE-1:0] acc_q [channels];
  logic [FLOAT_SIZE-1:0] acc_d [channels];
  logic [cnt_size-1:0]   cnt_q [channels];
  logic [cnt_size-1:0]   cnt_d [channels];

  always_comb begin
    for (int c = 0; c < channels; c++) begin
      acc_d[c] = acc_q[c];
      cnt_d[c] = cnt_q[c];
      if (clr_en && clr_chan == CHAN_W'(c)) begin
        acc_d[c] = FLOAT_ZERO;
        cnt_d[c] = '0;
      end else if (wr_en && wr_chan == CHAN_W'(c)) begin
        acc_d[c] = wr_data;
        if (cnt_q[c] != '1) cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < channels; c++) begin
        acc_q[c] <= FLOAT_ZERO;
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < channels; c++) begin
        acc_q[c] <= acc_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign acc_float = acc_q[acc_chan];
  assign rd_float  = acc_q[rd_chan];
  assign rd_count  = cnt_q[rd_chan];

endmodule

// File: rtl/reflet_float_add.sv
// rtl/reflet_float_add.sv - binary32 add/subtract, denormals flushed, rounding toward zero
module reflet_float_add
  import reflet_float_accumulator_pkg::*;
(
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  input  logic                  enable_sub,
  output logic [FLOAT_SIZE-1:0] result
);

  logic                 sa, sb, sl, ss, swap, sticky;
  logic [EXP_SIZE-1:0]  ea, eb, el, es, d;
  logic [MANT_SIZE-1:0] fa, fb, fl, fs;
  logic [27:0]          ml, ms, ms_sh, sum, norm;
  int                   pos, exp_r;
  logic                 unused_bits;

  always_comb begin
    sa = a[31];
    ea = a[30:23];
    fa = a[22:0];
    sb = b[31] ^ enable_sub;
    eb = b[30:23];
    fb = b[22:0];

    swap = {eb, fb} > {ea, fa};
    sl   = swap ? sb : sa;
    el   = swap ? eb : ea;
    fl   = swap ? fb : fa;
    ss   = swap ? sa : sb;
    es   = swap ? ea : eb;
    fs   = swap ? fa : fb;

    // 1 carry bit, hidden bit, 23 mantissa bits, 3 guard bits
    ml = {1'b0, el != '0, (el != '0) ? fl : 23'b0, 3'b0};
    ms = {1'b0, es != '0, (es != '0) ? fs : 23'b0, 3'b0};

    d        = el - es;
    ms_sh    = ms >> d;
    sticky   = (ms_sh << d) != ms;
    ms_sh[0] = ms_sh[0] | sticky;

    sum = (sl == ss) ? ml + ms_sh : ml - ms_sh;

    pos = 0;
    for (int i = 0; i < 28; i++) begin
      if (sum[i]) pos = i;
    end
    exp_r = int'(el) + pos - 26;
    norm  = (pos >= 26) ? (sum >> (pos - 26)) : (sum << (26 - pos));

    if (el == '1) begin
      result = swap ? {sb, b[30:0]} : a;
    end else if (sum == '0 || exp_r <= 0) begin
      result = FLOAT_ZERO;
    end else if (exp_r >= 255) begin
      result = {sl, 8'hFF, 23'b0};
    end else begin
      result = {sl, exp_r[7:0], norm[25:3]};
    end
    unused_bits = ^{norm[27:26], norm[2:0], exp_r[31:8]};
  end

endmodule

// File: rtl/reflet_float_to_int.sv
// rtl/reflet_float_to_int.sv - binary32 to signed integer, truncating and saturating
module reflet_float_to_int
  import reflet_float_accumulator_pkg::*;
#(
  parameter int int_size = 32
) (
  input  logic [FLOAT_SIZE-1:0] float_in,
  output logic [int_size-1:0]   int_out
);

  logic                sign;
  logic [23:0]         m24;
  logic [int_size-1:0] mag;
  int                  e;

  always_comb begin
    sign = float_in[31];
    m24  = {1'b1, float_in[22:0]};
    e    = int'(float_in[30:23]) - 127;
    mag  = '0;
    if (e >= 23) begin
      mag = int_size'(m24) << (e - 23);
    end else if (e >= 0) begin
      mag = int_size'(m24 >> (23 - e));
    end

    if (e < 0) begin
      int_out = '0;
    end else if (e >= int_size - 1) begin
      int_out = sign ? {1'b1, {(int_size-1){1'b0}}} : {1'b0, {(int_size-1){1'b1}}};
    end else begin
      int_out = sign ? -mag : mag;
    end
  end

endmodule

// File: rtl/reflet_int_to_float.sv
// rtl/reflet_int_to_float.sv - signed integer to binary32, rounding toward zero
module reflet_int_to_float
  import reflet_float_accumulator_pkg::*;
#(
  parameter int int_size = 32
) (
  input  logic [int_size-1:0]   int_in,
  output logic [FLOAT_SIZE-1:0] float_out
);

  logic                sign;
  logic [int_size-1:0] mag;
  logic [63:0]         norm;
  logic [EXP_SIZE-1:0] exp_f;
  int                  msb;
  logic                unused_bits;

  always_comb begin
    sign = int_in[int_size-1];
    mag  = sign ? -int_in : int_in;
    msb  = 0;
    for (int i = 0; i < int_size; i++) begin
      if (mag[i]) msb = i;
    end
    // Leading one lands on bit 63; the 23 bits below it are the mantissa.
    norm        = 64'(mag) << (63 - msb);
    exp_f       = EXP_SIZE'(127 + msb);
    float_out   = (mag == '0) ? FLOAT_ZERO : {sign, exp_f, norm[62:40]};
    unused_bits = ^{norm[63], norm[39:0]};
  end

endmodule

// File: rtl/reflet_float_accumulator.sv
// rtl/reflet_float_accumulator.sv - multi-channel binary32 accumulator with int/float operands
module reflet_float_accumulator
  import reflet_float_accumulator_pkg::*;
#(
  parameter int channels = 4,
  parameter int int_size = 32,
  parameter int cnt_size = 16,
  localparam int CHAN_W  = $clog2(channels)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_SIZE-1:0] in_data,
  input  logic                  in_is_int,
  input  logic                  in_sub,
  input  logic [CHAN_W-1:0]     in_chan,
  input  logic                  clear,
  input  logic [CHAN_W-1:0]     clear_chan,
  output logic                  done,
  input  logic [CHAN_W-1:0]     rd_chan,
  output logic [FLOAT_SIZE-1:0] rd_float,
  output logic [int_size-1:0]   rd_int,
  output logic [cnt_size-1:0]   rd_count
);

  acc_state_t            state_q, state_d;
  logic [FLOAT_SIZE-1:0] op_q, op_d;
  logic                  is_int_q, is_int_d;
  logic                  sub_q, sub_d;
  logic [CHAN_W-1:0]     chan_q, chan_d;
  logic [FLOAT_SIZE-1:0] operand_q, operand_d;
  logic [FLOAT_SIZE-1:0] sum_q, sum_d;
  logic                  done_q, done_d;

  logic                  accept, clr_en, wr_en;
  logic [FLOAT_SIZE-1:0] conv_float, sum_float, acc_float;

  reflet_int_to_float #(.int_size(int_size)) u_int_to_float (
    .int_in   (op_q[int_size-1:0]),
    .float_out(conv_float)
  );

  reflet_float_add u_float_add (
    .a         (acc_float),
    .b         (operand_q),
    .enable_sub(sub_q),
    .result    (sum_float)
  );

  reflet_float_to_int #(.int_size(int_size)) u_float_to_int (
    .float_in(rd_float),
    .int_out (rd_int)
  );

  reflet_float_acc_bank #(.channels(channels), .cnt_size(cnt_size)) u_bank (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (clr_en),
    .clr_chan (clear_chan),
    .wr_en    (wr_en),
    .wr_chan  (chan_q),
    .wr_data  (sum_q),
    .acc_chan (chan_q),
    .acc_float(acc_float),
    .rd_chan  (rd_chan),
    .rd_float (rd_float),
    .rd_count (rd_count)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    is_int_d  = is_int_q;
    sub_d     = sub_q;
    chan_d    = chan_q;
    operand_d = operand_q;
    sum_d     = sum_q;
    done_d    = 1'b0;
    wr_en     = 1'b0;
    // A clear in IDLE takes priority and blocks acceptance that cycle.
    in_ready  = (state_q == ST_IDLE) && !clear;
    clr_en    = (state_q == ST_IDLE) && clear;
    accept    = in_valid && in_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = in_data;
          is_int_d = in_is_int;
          sub_d    = in_sub;
          chan_d   = in_chan;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        operand_d = is_int_q ? conv_float : op_q;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = sum_float;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      is_int_q  <= 1'b0;
      sub_q     <= 1'b0;
      chan_q    <= '0;
      operand_q <= FLOAT_ZERO;
      sum_q     <= FLOAT_ZERO;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      is_int_q  <= is_int_d;
      sub_q     <= sub_d;
      chan_q    <= chan_d;
      operand_q <= operand_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_reflet_float_accumulator.sv
// tb/tb_reflet_float_accumulator.sv - self-checking bench for reflet_float_accumulator
module tb_reflet_float_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_is_int = 1'b0;
  logic        in_sub = 1'b0;
  logic [1:0]  in_chan = '0;
  logic        clear = 1'b0;
  logic [1:0]  clear_chan = '0;
  logic [1:0]  rd_chan = '0;

  logic        in_ready, done;
  logic [31:0] rd_float, rd_int;
  logic [15:0] rd_count;
  logic        in_ready2, done2;
  logic [31:0] rd_float2, rd_int2;
  logic [1:0]  rd_count2;

  int tests = 0;
  int failed = 0;
  real model_acc [4];
  int  model_cnt [4];

  typedef struct {
    logic [31:0] data;
    logic        is_int;
    logic        sub;
    logic [1:0]  chan;
    logic [31:0] ef;
    int          ei;
    int          ec;
  } vec_t;

  vec_t vecs [9];

  reflet_float_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_is_int(in_is_int), .in_sub(in_sub), .in_chan(in_chan),
    .clear(clear), .clear_chan(clear_chan), .done(done), .rd_chan(rd_chan),
    .rd_float(rd_float), .rd_int(rd_int), .rd_count(rd_count)
  );

  reflet_float_accumulator #(.cnt_size(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_is_int(in_is_int), .in_sub(in_sub), .in_chan(in_chan),
    .clear(clear), .clear_chan(clear_chan), .done(done2), .rd_chan(rd_chan),
    .rd_float(rd_float2), .rd_int(rd_int2), .rd_count(rd_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] b;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      model_acc[c] = 0.0;
      model_cnt[c] = 0;
    end
  endtask

  task automatic do_op(input logic [31:0] data, input logic is_int, input logic sub,
                       input logic [1:0] chan, input string tag);
    int waited;
    int lat;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 10) begin
      tests++; failed++;
      $display("FAIL %s_ready_timeout: in_ready stayed 0, expected 1", tag);
    end
    in_data = data; in_is_int = is_int; in_sub = sub; in_chan = chan; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = $urandom; in_is_int = 1'($urandom); in_sub = 1'($urandom); in_chan = 2'($urandom);
    lat = 0;
    while (!done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done_latency"}, 32'(lat), 32'd3);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  task automatic rd_expect(input int chan, input logic [31:0] ef, input int ei,
                           input int ec, input string tag);
    rd_chan = 2'(chan);
    #1;
    check({tag, "_float"}, rd_float, ef);
    check({tag, "_int"}, rd_int, 32'(ei));
    check({tag, "_count"}, 32'(rd_count), 32'(ec));
  endtask

  task automatic rd_model(input int chan, input string tag);
    int c2;
    rd_expect(chan, to_f32(model_acc[chan]), $rtoi(model_acc[chan]), model_cnt[chan], tag);
    c2 = (model_cnt[chan] > 3) ? 3 : model_cnt[chan];
    check({tag, "_count_sat2"}, 32'(rd_count2), 32'(c2));
  endtask

  initial begin
    vecs[0] = '{32'd28,         1'b1, 1'b0, 2'd2, 32'h41E00000,  28, 1};
    vecs[1] = '{32'd15,         1'b1, 1'b1, 2'd2, 32'h41500000,  13, 2};
    vecs[2] = '{32'd5,          1'b1, 1'b0, 2'd0, 32'h40A00000,   5, 1};
    vecs[3] = '{32'd15,         1'b1, 1'b0, 2'd0, 32'h41A00000,  20, 2};
    vecs[4] = '{32'h3FC00000,   1'b0, 1'b1, 2'd1, 32'hBFC00000,  -1, 1};
    vecs[5] = '{32'h3FC00000,   1'b0, 1'b1, 2'd1, 32'hC0400000,  -3, 2};
    vecs[6] = '{32'hFFFFFFF9,   1'b1, 1'b0, 2'd3, 32'hC0E00000,  -7, 1};
    vecs[7] = '{32'h40200000,   1'b0, 1'b0, 2'd3, 32'hC0900000,  -4, 2};
    vecs[8] = '{32'd4,          1'b1, 1'b1, 2'd3, 32'hC1080000,  -8, 3};

    // Reset state
    do_reset();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    for (int c = 0; c < 4; c++) rd_expect(c, 32'h0, 0, 0, $sformatf("reset_ch%0d", c));

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].data, vecs[i].is_int, vecs[i].sub, vecs[i].chan, $sformatf("vec%0d", i));
      rd_expect(int'(vecs[i].chan), vecs[i].ef, vecs[i].ei, vecs[i].ec, $sformatf("vec%0d", i));
      if (i == 1) begin
        rd_expect(0, 32'h0, 0, 0, "isolate_ch0");
        rd_expect(1, 32'h0, 0, 0, "isolate_ch1");
        rd_expect(3, 32'h0, 0, 0, "isolate_ch3");
      end
    end

    // Randomized operations against an arithmetic model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int v;
      int ch;
      int other;
      logic is_int;
      logic sub;
      logic [31:0] data;
      v = int'($urandom_range(2000)) - 1000;
      ch = int'($urandom_range(3));
      is_int = 1'($urandom);
      sub = 1'($urandom);
      data = is_int ? 32'(v) : to_f32(real'(v));
      do_op(data, is_int, sub, 2'(ch), $sformatf("rand%0d", n));
      model_acc[ch] = sub ? model_acc[ch] - real'(v) : model_acc[ch] + real'(v);
      model_cnt[ch]++;
      rd_model(ch, $sformatf("rand%0d_ch%0d", n, ch));
      other = int'($urandom_range(3));
      rd_model(other, $sformatf("rand%0d_other%0d", n, other));
    end

    // Counter saturation and clear handling
    do_reset();
    for (int n = 0; n < 5; n++) begin
      do_op(32'd1, 1'b1, 1'b0, 2'd3, $sformatf("sat%0d", n));
      model_acc[3] += 1.0;
      model_cnt[3]++;
    end
    rd_model(3, "sat_ch3");
    in_data = 32'd1; in_is_int = 1'b1; in_sub = 1'b0; in_chan = 2'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear = 1'b1;
    clear_chan = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    check("busy_clear_done", 32'(done), 32'd1);
    clear = 1'b0;
    model_acc[3] += 1.0;
    model_cnt[3]++;
    rd_model(3, "busy_clear_ch3");
    clear = 1'b1; clear_chan = 2'd3;
    in_data = 32'd100; in_is_int = 1'b1; in_chan = 2'd3; in_valid = 1'b1;
    #1;
    check("clear_blocks_ready", 32'(in_ready), 32'd0);
    check("clear_blocks_ready2", 32'(in_ready2), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    model_acc[3] = 0.0;
    model_cnt[3] = 0;
    rd_model(3, "idle_clear_ch3");
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        saw_done |= done;
      end
      check("clear_no_accept_done", 32'(saw_done), 32'd0);
    end
    rd_model(3, "idle_clear_after_ch3");

    // Reset while the operation is in ADD
    do_reset();
    in_data = 32'd9; in_is_int = 1'b1; in_sub = 1'b0; in_chan = 2'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_busy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        saw_done |= done;
      end
      check("midop_no_done", 32'(saw_done), 32'd0);
    end
    check("midop_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) rd_expect(c, 32'h0, 0, 0, $sformatf("midop_ch%0d", c));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
